// File: rtl/add_nnbit_digit_serial_if.sv
// ---------------------------------------------------------------------------
// add_nnbit_digit_serial_if
//
// Purpose:
//   Handshake and data bundle for the digit-serial adder. The requester
//   (master) presents operands with a valid/ready handshake and consumes the
//   result with a second valid/ready handshake. The adder (slave) drives the
//   ready, valid and result signals.
//
// Signals:
//   i_valid    master -> slave  operand request valid
//   o_ready    slave  -> master adder can accept operands
//   i_num_a    master -> slave  operand A, DATA_WIDTH bits
//   i_num_b    master -> slave  operand B, DATA_WIDTH bits
//   i_cry      master -> slave  carry-in
//   i_sub      master -> slave  subtract select (only with
//                               ADD_NNBIT_DIGIT_SERIAL_SUB_EN defined)
//   o_valid    slave  -> master result valid
//   i_ready    master -> slave  requester accepts the result
//   o_res      slave  -> master sum, DATA_WIDTH bits
//   o_cry      slave  -> master carry-out of the top bit
//
// Optional feature macro: ADD_NNBIT_DIGIT_SERIAL_SUB_EN adds i_sub.
// ---------------------------------------------------------------------------
interface add_nnbit_digit_serial_if #(
    parameter int DATA_WIDTH = 8
);

    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] i_num_a;
    logic [DATA_WIDTH-1:0] i_num_b;
    logic                  i_cry;
`ifdef ADD_NNBIT_DIGIT_SERIAL_SUB_EN
    logic                  i_sub;
`endif
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_res;
    logic                  o_cry;

    modport master (
        output i_valid, i_num_a, i_num_b, i_cry, i_ready,
`ifdef ADD_NNBIT_DIGIT_SERIAL_SUB_EN
        output i_sub,
`endif
        input  o_ready, o_valid, o_res, o_cry
    );

    modport slave (
        input  i_valid, i_num_a, i_num_b, i_cry, i_ready,
`ifdef ADD_NNBIT_DIGIT_SERIAL_SUB_EN
        input  i_sub,
`endif
        output o_ready, o_valid, o_res, o_cry
    );

endinterface

// File: rtl/add_nnbit_digit_serial.sv
// ---------------------------------------------------------------------------
// add_nnbit_digit_serial
//
// Purpose:
//   Multi-cycle digit-serial carry adder. Operands are captured on the
//   accepting edge, then one DIGIT_WIDTH-bit slice is added per cycle, LSB
//   digit first, with the carry held in a register between digits. After
//   NUM_DIGITS cycles of calculation the result is published and held until
//   the requester takes it.
//
// Ports:
//   i_clk   clock, rising edge
//   i_rst   asynchronous reset, active-high
//   bus     add_nnbit_digit_serial_if.slave: operand valid/ready, operands,
//           carry-in, result valid/ready, sum and carry-out
//
// Parameters:
//   DATA_WIDTH   operand/result width in bits (>= 1)
//   DIGIT_WIDTH  bits added per cycle; must divide DATA_WIDTH exactly
//
// Optional feature macro: ADD_NNBIT_DIGIT_SERIAL_SUB_EN
//   When defined, bus.i_sub selects A - B - i_cry, computed as
//   A + ~B + ~i_cry; o_cry then reads 1 for "no borrow".
//   When undefined the datapath is the same with the subtract select tied
//   to 0.
// ---------------------------------------------------------------------------
module add_nnbit_digit_serial #(
    parameter int DATA_WIDTH  = 8,
    parameter int DIGIT_WIDTH = 2
) (
    input logic                     i_clk,
    input logic                     i_rst,
    add_nnbit_digit_serial_if.slave bus
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam int NUM_DIGITS = (DIGIT_WIDTH > 0) ? (DATA_WIDTH / DIGIT_WIDTH) : 1;
    localparam int CNT_WIDTH  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_WIDTH-1:0] LAST_DIGIT = CNT_WIDTH'(NUM_DIGITS - 1);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------
    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $error("add_nnbit_digit_serial: DATA_WIDTH must be >= 1");
    end

    if (DIGIT_WIDTH < 1) begin : g_bad_digit_width
        $error("add_nnbit_digit_serial: DIGIT_WIDTH must be >= 1");
    end else if ((DATA_WIDTH % DIGIT_WIDTH) != 0) begin : g_bad_digit_split
        $error("add_nnbit_digit_serial: DIGIT_WIDTH must divide DATA_WIDTH");
    end

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    logic [1:0]            state;
    logic [1:0]            state_next;

    logic [DATA_WIDTH-1:0] a_sr;     // operand A, consumed from the bottom
    logic [DATA_WIDTH-1:0] b_sr;     // operand B (inverted when subtracting)
    logic [DATA_WIDTH-1:0] res_sr;   // partial sum, filled from the top
    logic                  carry;    // carry between digits
    logic [CNT_WIDTH-1:0]  cnt;      // index of the digit being added

    logic [DATA_WIDTH-1:0] res_q;    // published sum
    logic                  cry_q;    // published carry-out

    // -----------------------------------------------------------------------
    // Operand conditioning at acceptance
    // -----------------------------------------------------------------------
    logic                  sub_sel;
    logic [DATA_WIDTH-1:0] b_load;
    logic                  carry_load;

`ifdef ADD_NNBIT_DIGIT_SERIAL_SUB_EN
    assign sub_sel = bus.i_sub;
`else
    assign sub_sel = 1'b0;
`endif

    // Subtraction is A + ~B + ~cin, so both B and the carry-in are simply
    // inverted on the way into the registers; the adder itself never changes.
    assign b_load     = bus.i_num_b ^ {DATA_WIDTH{sub_sel}};
    assign carry_load = bus.i_cry ^ sub_sel;

    // -----------------------------------------------------------------------
    // Digit adder and result shifter
    // -----------------------------------------------------------------------
    logic [DIGIT_WIDTH:0]  digit_sum;
    logic [DATA_WIDTH-1:0] digit_ext;
    logic [DATA_WIDTH-1:0] res_shift;
    logic                  last_digit;

    assign digit_sum = {1'b0, a_sr[DIGIT_WIDTH-1:0]}
                     + {1'b0, b_sr[DIGIT_WIDTH-1:0]}
                     + {{DIGIT_WIDTH{1'b0}}, carry};

    // New digit enters at the top while earlier digits move down, so after
    // NUM_DIGITS shifts the first (least significant) digit sits at bit 0.
    // Written as shifts rather than a slice concatenation so the
    // DIGIT_WIDTH == DATA_WIDTH case needs no special handling.
    assign digit_ext = DATA_WIDTH'(digit_sum[DIGIT_WIDTH-1:0]);
    assign res_shift = (res_sr >> DIGIT_WIDTH)
                     | (digit_ext << (DATA_WIDTH - DIGIT_WIDTH));

    assign last_digit = (cnt == LAST_DIGIT);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: state_next gets a default before any branch so every path
        // assigns it and no latch is inferred.
        state_next = state;
        case (state)
            ST_IDLE: if (bus.i_valid)  state_next = ST_CALC;
            ST_CALC: if (last_digit)   state_next = ST_DONE;
            ST_DONE: if (bus.i_ready)  state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            res_q  <= '0;
            cry_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Operands are sampled only here; anything presented
                    // while busy is ignored.
                    if (bus.i_valid) begin
                        a_sr  <= bus.i_num_a;
                        b_sr  <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                    end
                end

                ST_CALC: begin
                    a_sr   <= a_sr >> DIGIT_WIDTH;
                    b_sr   <= b_sr >> DIGIT_WIDTH;
                    res_sr <= res_shift;
                    carry  <= digit_sum[DIGIT_WIDTH];
                    cnt    <= cnt + 1'b1;
                    // Published outputs change only on entry to DONE, so
                    // they hold the last result between transactions.
                    if (last_digit) begin
                        res_q <= res_shift;
                        cry_q <= digit_sum[DIGIT_WIDTH];
                    end
                end

                default: begin
                    // DONE: hold everything until the result is taken.
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: handshake flags decode the state register only
    // -----------------------------------------------------------------------
    assign bus.o_ready = (state == ST_IDLE);
    assign bus.o_valid = (state == ST_DONE);
    assign bus.o_res   = res_q;
    assign bus.o_cry   = cry_q;

endmodule
